// File: rtl/periph_int_ctrl.sv
// Peripheral interrupt controller: masks SRC_NUM lines, fixed-priority arbitration and a claim/complete handshake.
// Optional macro PIC_EDGE_TRIG_EN adds the TRIGGER register and per-source edge detection.
module periph_int_ctrl #(
    parameter int SRC_NUM        = 8,
    parameter int INT_CODE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SRC_NUM-1:0]        irq_src,
    input  logic                      reg_wr_en,
    input  logic                      reg_rd_en,
    input  logic [1:0]                reg_addr,
    input  logic [31:0]               reg_wdata,
    output logic [31:0]               reg_rdata,
    output logic [INT_CODE_WIDTH-1:0] peripheral_int_code,
    output logic [1:0]                fsm_state
);

    // Register port: reg_wr_en / reg_rd_en are single-cycle strobes with no ready
    // back-pressure; every strobe is accepted at the edge that samples it.
    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_PENDING = 2'd1;
    localparam logic [1:0] A_CLAIM   = 2'd2;
    localparam logic [1:0] A_TRIGGER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [INT_CODE_WIDTH-1:0] code_q, code_d;
    logic [SRC_NUM-1:0]        enable_q;
    logic [SRC_NUM-1:0]        pending_q, pending_d;
    logic [SRC_NUM-1:0]        req, sel_vec;
    logic                      win_valid, lost;
    logic [INT_CODE_WIDTH-1:0] win_code;
    logic                      claim_rd, complete_wr, claim_fire;
    logic [31:0]               en32, pend32, code32, trig32, rd_mux;
    logic                      unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign claim_rd     = reg_rd_en && (reg_addr == A_CLAIM);
    assign complete_wr  = reg_wr_en && (reg_addr == A_CLAIM);
    assign req          = pending_q & enable_q;

    always_comb begin
        win_valid = 1'b0;
        win_code  = '0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_code  = INT_CODE_WIDTH'(i + 1);
            end
        end
    end

    // One-hot of the latched source, used for withdraw detection and claim clearing.
    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < SRC_NUM; i++) begin
            sel_vec[i] = (code_q == INT_CODE_WIDTH'(i + 1));
        end
    end
    assign lost = ~|(req & sel_vec);

`ifdef PIC_EDGE_TRIG_EN
    logic [SRC_NUM-1:0] trigger_q, irq_prev_q, claim_vec;

    assign claim_vec = sel_vec & {SRC_NUM{claim_fire}};
    // A new edge wins over a claim of the same source, so it is never lost.
    assign pending_d = (trigger_q & ((pending_q & ~claim_vec) | (irq_src & ~irq_prev_q)))
                     | (~trigger_q & irq_src);

    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_q  <= '0;
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_src;
            if (reg_wr_en && (reg_addr == A_TRIGGER)) begin
                trigger_q <= reg_wdata[SRC_NUM-1:0];
            end
        end
    end

    always_comb begin
        trig32              = '0;
        trig32[SRC_NUM-1:0] = trigger_q;
    end
`else
    assign pending_d = irq_src;
    assign trig32    = '0;
`endif

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        claim_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    code_d  = win_code;
                    state_d = ST_PRESENT;
                end else begin
                    code_d = '0;
                end
            end
            ST_PRESENT: begin
                if (lost) begin
                    code_d  = '0;
                    state_d = ST_IDLE;
                end else if (claim_rd) begin
                    claim_fire = 1'b1;
                    state_d    = ST_CLAIMED;
                end
            end
            ST_CLAIMED: begin
                if (complete_wr && (reg_wdata[INT_CODE_WIDTH-1:0] == code_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                code_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            if (reg_wr_en && (reg_addr == A_ENABLE)) begin
                enable_q <= reg_wdata[SRC_NUM-1:0];
            end
        end
    end

    always_comb begin
        en32                = '0;
        en32[SRC_NUM-1:0]   = enable_q;
        pend32              = '0;
        pend32[SRC_NUM-1:0] = pending_q;
        code32              = '0;
        code32[INT_CODE_WIDTH-1:0] = code_q;
        case (reg_addr)
            A_ENABLE:  rd_mux = en32;
            A_PENDING: rd_mux = pend32;
            A_CLAIM:   rd_mux = claim_fire ? code32 : 32'd0;
            default:   rd_mux = trig32;
        endcase
    end

    // Read data comes from pre-edge register values, so a same-cycle write is not visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata <= '0;
        end else if (reg_rd_en) begin
            reg_rdata <= rd_mux;
        end
    end

    assign peripheral_int_code = (state_q == ST_PRESENT) ? code_q : '0;
    assign fsm_state           = state_q;

endmodule

// File: doc/periph_int_ctrl.md
# periph_int_ctrl

Peripheral interrupt controller sitting directly upstream of the CSR register file. It collects up to `SRC_NUM` peripheral interrupt lines, masks them and arbitrates by fixed priority, lowest index wins. It presents the winner as a non-zero `peripheral_int_code`, which the CSR file turns into mip[11] and mcause 11. A memory-mapped claim/complete handshake lets the trap handler identify the source and re-arm the controller.

## Interface
Parameters:
- SRC_NUM, 8: number of interrupt sources, 1..(2^`INT_CODE_WIDTH`-1); source i reports code i+1, code 0 = none.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous active-high.
- irq_src  input  SRC_NUM  raw peripheral interrupt lines, synchronous to clk.
- reg_wr_en  input  1  register write strobe.
- reg_rd_en  input  1  register read strobe.
- reg_addr  input  2  register select: 0 ENABLE, 1 PENDING (RO), 2 CLAIM/COMPLETE, 3 TRIGGER.
- reg_wdata  input  32  write data; bits above SRC_NUM-1 ignored.
- reg_rdata  output  32  read data, registered.
- peripheral_int_code  output  `INT_CODE_WIDTH`  presented interrupt code to CSR file; 0 = no request.

## Operation
- Registers: ENABLE[SRC_NUM-1:0] RW; PENDING RO (writes ignored); TRIGGER RW, bit=1 edge, 0 level; CLAIM read = claim, CLAIM write = complete with ID reg_wdata[`INT_CODE_WIDTH`-1:0]. Unimplemented bits read 0.
- Pending update each clk: level source: pending[i] <= irq_src[i]; edge source: pending[i] <= (pending[i] & ~claim_i) | (irq_src[i] & ~irq_prev[i]). irq_prev registered every cycle.
- Simultaneous new edge and claim of the same edge source: pending stays 1.
- Arbitration: winner = lowest i with pending[i] & ENABLE[i]; combinational.
- FSM, states IDLE, PRESENT, CLAIMED:
  - IDLE: a winner exists -> latch code=i+1, go PRESENT; else stay, code register 0.
  - PRESENT: peripheral_int_code = latched code. On a CLAIM read: return code, clear edge pending of that source, go CLAIMED. If the latched source loses pending&enable before claim, withdraw: code 0, go IDLE.
  - CLAIMED: output 0; on a CLAIM write whose ID equals the latched code -> IDLE. A mismatched ID is ignored and the FSM stays in CLAIMED.
- CLAIM read in IDLE or CLAIMED returns 0 and has no side effect.
- Read and write in the same cycle: write updates state, read returns pre-write value.
- No nesting: only one interrupt in service at a time.

## Timing
- Reset values: ENABLE=0, PENDING=0, TRIGGER=0, irq_prev=0, FSM=IDLE, peripheral_int_code=0, reg_rdata=0.
- Reset mid-service (any state) returns to IDLE immediately at the reset edge; in-service interrupt is dropped.
- Latency: irq_src high before edge k -> pending at k -> peripheral_int_code valid after edge k+1 (2 cycles).
- reg_rdata valid the cycle after reg_rd_en; holds until next read.
- Claim takes effect at the edge sampling reg_rd_en; peripheral_int_code is 0 the following cycle.
- After a matching complete at edge c, IDLE; a still-pending source is re-presented after edge c+1.
- ENABLE write at edge w affects arbitration from cycle w+1.

## Configuration
- PIC_EDGE_TRIG_EN defined: TRIGGER register and edge detection implemented as above.
- Not defined: all sources level-sensitive, irq_prev logic absent, TRIGGER reads 0 and writes are ignored.

## Test plan
- Reset: assert rst 2 cycles with irq_src=8'hFF -> all registers 0, peripheral_int_code=0.
- Priority: ENABLE=8'hFF, irq_src=8'b1010_0000 -> code 6 after 2 cycles; claim reads 6; complete(6), source 5 still high -> code 6 again; drop bit 5 -> code 8.
- Masking and withdraw: ENABLE=8'h04, irq_src[2] high -> code 3; deassert before claim -> code 0, FSM IDLE, CLAIM read returns 0.
- Mismatched complete: claim code 2, write complete ID 5 -> still CLAIMED and code 0 with irq_src[1] held; complete ID 2 -> code 2 re-presented.
- Edge mode (PIC_EDGE_TRIG_EN): TRIGGER=8'h01, 1-cycle pulse on irq_src[0] -> PENDING=1, code 1; claim clears PENDING; pulse during claim cycle -> PENDING stays 1.
- Reset mid-service: claim code 4, assert rst -> next cycle IDLE, code 0, ENABLE 0.
